// File: rtl/led_fader_pkg.sv
// Shared types and the saturating level step for the LED fader.
package led_fader_pkg;

  localparam int LED_FADER_PWM_BITS = 8;

  typedef logic [LED_FADER_PWM_BITS-1:0] level_t;

  localparam level_t LEVEL_MAX = '1;

  // One extra bit catches the carry so the upward step clamps instead of wrapping
  function automatic level_t sat_step(input level_t level, input level_t step, input logic up);
    logic [LED_FADER_PWM_BITS:0] sum;
    sum = {1'b0, level} + {1'b0, step};
    if (up) begin
      sat_step = sum[LED_FADER_PWM_BITS] ? LEVEL_MAX : sum[LED_FADER_PWM_BITS-1:0];
    end else begin
      sat_step = (level > step) ? level - step : '0;
    end
  endfunction

endpackage

// File: rtl/led_fader_channel.sv
// One LED: brightness level register, fade/bypass update, duty mapping and PWM compare.
// LED_FADER_GAMMA_EN selects a square-law duty curve instead of linear.
module led_fader_channel
  import led_fader_pkg::*;
#(
  parameter int PWM_BITS = LED_FADER_PWM_BITS,
  parameter int STEP     = 16
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                target,
  input  logic                fade_en,
  input  logic                step_tick,
  input  logic [PWM_BITS-1:0] pwm_cnt,
  output logic                led_out,
  output logic                at_target
);

  localparam logic [PWM_BITS-1:0] MAX    = '1;
  localparam logic [PWM_BITS-1:0] STEP_W = PWM_BITS'(STEP);

  logic [PWM_BITS-1:0] level_reg;
  logic [PWM_BITS-1:0] level_next;
  logic [PWM_BITS-1:0] stepped;
  logic [PWM_BITS-1:0] endpoint;
  logic [PWM_BITS-1:0] duty;

  assign endpoint  = target ? MAX : '0;
  assign at_target = (level_reg == endpoint);

  // The package helper is fixed at the default width; other widths use the same arithmetic inline
  generate
    if (PWM_BITS == LED_FADER_PWM_BITS) begin : g_pkg_step
      assign stepped = sat_step(level_reg, STEP_W, target);
    end else begin : g_wide_step
      logic [PWM_BITS:0] sum;
      assign sum     = {1'b0, level_reg} + {1'b0, STEP_W};
      assign stepped = target ? (sum[PWM_BITS] ? MAX : sum[PWM_BITS-1:0])
                              : ((level_reg > STEP_W) ? level_reg - STEP_W : '0);
    end
  endgenerate

  always_comb begin
    level_next = level_reg;
    if (!fade_en) begin
      level_next = endpoint;
    end else if (step_tick) begin
      level_next = stepped;
    end
  end

`ifdef LED_FADER_GAMMA_EN
  logic [2*PWM_BITS-1:0] square;
  assign square = {{PWM_BITS{1'b0}}, level_reg} * {{PWM_BITS{1'b0}}, level_reg};
  assign duty   = square[2*PWM_BITS-1:PWM_BITS];
`else
  assign duty = level_reg;
`endif

  // Full-scale override keeps MAX solidly on instead of dropping one count per period
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      level_reg <= '0;
      led_out   <= 1'b0;
    end else begin
      level_reg <= level_next;
      led_out   <= (level_reg == MAX) | (duty > pwm_cnt);
    end
  end

endmodule

// File: rtl/led_fader.sv
// Fade and PWM stage between the LED PIO register and the pins: input register,
// shared PWM counter and step prescaler, one channel per LED (gamma via LED_FADER_GAMMA_EN).
module led_fader
  import led_fader_pkg::*;
#(
  parameter int NUM_LEDS = 8,
  parameter int PWM_BITS = LED_FADER_PWM_BITS,
  parameter int STEP_DIV = 1024,
  parameter int STEP     = 16
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic [NUM_LEDS-1:0] data_in,
  input  logic                fade_en,
  output logic [NUM_LEDS-1:0] led_out,
  output logic                busy
);

  localparam int               DIV_W    = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(STEP_DIV - 1);

  logic [NUM_LEDS-1:0] data_reg;
  logic [NUM_LEDS-1:0] at_target;
  logic [PWM_BITS-1:0] pwm_cnt_reg;
  logic [DIV_W-1:0]    prescale_reg;
  logic                step_tick;

  // With STEP_DIV=1 the prescaler sits at 0 == DIV_LAST, so every cycle ticks
  assign step_tick = (prescale_reg == DIV_LAST);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      data_reg     <= '0;
      pwm_cnt_reg  <= '0;
      prescale_reg <= '0;
      busy         <= 1'b0;
    end else begin
      data_reg     <= data_in;
      pwm_cnt_reg  <= pwm_cnt_reg + 1'b1;
      prescale_reg <= step_tick ? '0 : prescale_reg + 1'b1;
      busy         <= ~&at_target;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < NUM_LEDS; gi++) begin : g_ch
      led_fader_channel #(
        .PWM_BITS(PWM_BITS),
        .STEP    (STEP)
      ) u_ch (
        .clk      (clk),
        .reset_n  (reset_n),
        .target   (data_reg[gi]),
        .fade_en  (fade_en),
        .step_tick(step_tick),
        .pwm_cnt  (pwm_cnt_reg),
        .led_out  (led_out[gi]),
        .at_target(at_target[gi])
      );
    end
  endgenerate

endmodule

// File: doc/led_fader.md
# led_fader

Per-LED fade and PWM stage sitting directly downstream of the 8-bit LED PIO register, between its output port and the board LED pins. Each bit of the PIO word is a per-LED on/off target. The block ramps each LED's brightness level toward that target at a fixed rate and drives the pin with a PWM waveform. Software keeps writing plain on/off patterns; fading happens in hardware.

## Interface
- NUM_LEDS, 8, number of channels; width of data_in and led_out.
- PWM_BITS, 8, width of brightness level and PWM counter; MAX = 2^PWM_BITS-1.
- STEP_DIV, 1024, clk cycles per fade step; must be ≥1.
- STEP, 16, level increment/decrement per fade step; range 1..MAX.
- clk  in  1  system clock; same domain as the PIO register.
- reset_n  in  1  asynchronous, active-low reset.
- data_in  in  NUM_LEDS  target word from the PIO output port; bit i=1 means LED i on.
- fade_en  in  1  1 = ramp levels; 0 = levels jump straight to target.
- led_out  out  NUM_LEDS  PWM-modulated LED drive, registered.
- busy  out  1  registered; 1 while any channel level differs from its target endpoint.

## Operation
- Reset: data_r=0, all levels=0, pwm_cnt=0, prescaler=0, led_out=0, busy=0.
- data_r: data_in registered every cycle. No synchroniser, because the input is same-clock.
- pwm_cnt: free-running PWM_BITS counter, +1 every cycle, wraps MAX→0.
- Prescaler: counts 0..STEP_DIV-1, then wraps to 0. step_tick=1 for the single cycle where prescaler==STEP_DIV-1. With STEP_DIV=1, step_tick is always 1.
- Per channel, when fade_en=1 and step_tick=1:
  - Target 1 (data_r[i]=1): level += STEP, saturating at MAX. Compute in PWM_BITS+1 bits and clamp.
  - Target 0: level -= STEP, saturating at 0.
  - Level already at target endpoint: hold.
- fade_en=0: every cycle, level = data_r[i] ? MAX : 0, regardless of step_tick.
- Target reversal mid-ramp: the ramp reverses from the current level on the next step_tick. No restart from an endpoint.
- Duty: duty = level.
- PWM compare: led_out[i] <= (level==MAX) | (duty > pwm_cnt).
  - level 0 gives constant 0.
  - MAX gives constant 1, with no 1/256 glitch.
  - Otherwise on-time is duty cycles per 2^PWM_BITS-cycle period.
- busy <= OR over i of (level[i] != (data_r[i] ? MAX : 0)).
- Prescaler and pwm_cnt never stop and are not affected by fade_en or data changes.

## Timing
- data_in sampled at edge N into data_r.
- Bypass (fade_en=0): level loaded at edge N+1, led_out updated at N+2. Two-cycle latency to full on/off.
- Fade: the first level change happens on the first step_tick edge after N+1. A full ramp 0→MAX takes ceil(MAX/STEP) step_ticks.
- led_out always trails level and pwm_cnt by one register stage.
- busy trails level by one cycle.
- Reset asserted mid-ramp: all state clears immediately (asynchronously). After release, behaviour restarts as from power-up.

## Configuration
- LED_FADER_GAMMA_EN defined: duty = (level*level) >> PWM_BITS, using a 2·PWM_BITS-bit product. This gives a perceptual square-law curve. The level==MAX full-on override still applies, and level 0 still gives constant off.
- LED_FADER_GAMMA_EN undefined: duty = level (linear). No multiplier is instantiated.
- Levels, busy and ramp timing are identical in both builds; only the led_out duty differs.

## Structure
- Package led_fader_pkg holds:
  - the level_t typedef (logic [PWM_BITS-1:0]) with default width constant LED_FADER_PWM_BITS=8;
  - a function sat_step(level, step, up) returning the saturated next level.
- Sub-module led_fader_channel holds, per LED:
  - level register, saturating step logic, bypass load, duty (gamma under the macro), compare, and led_out flop.
  - It exposes at_target for the busy OR.
- Top led_fader holds data_r, pwm_cnt, the prescaler and the generate loop of NUM_LEDS channels.

## Test plan
Default test configuration: PWM_BITS=8, STEP_DIV=4, STEP=64, gamma off unless stated.

- Reset, data_in=0xFF, fade_en=1: levels step 0→64→128→192→255 on successive step_ticks (every 4 cycles). busy is 1 until the level reaches 255, then 0. led_out[0] high 128/256 cycles per period at level 128.
- fade_en=0, data_in 0x00→0xA5: led_out==0xA5 constantly from 2 cycles after the input edge. busy pulses at most one cycle.
- Reversal: data_in bit0 set, then cleared when level=128: next step_tick gives 64, then 0. No jump to 255.
- Saturation: STEP=200, target 1: level 0→200→255. Target 0: level 255→55→0. No wrap at either end.
- Reset asserted mid-ramp (level=192): led_out=0, busy=0 and level=0 immediately. After release, the ramp restarts from 0.
- LED_FADER_GAMMA_EN build: level 128 gives duty 64, i.e. led_out high 64 of 256 cycles. level 255 gives constant high.
